sync_fifo_ext: RTL and testbench
================================

# sync_fifo_ext

Parametrised synchronous FIFO, the next generation of the team's single-clock byte FIFO. It uses every entry of storage through extended (N+1-bit) pointers and reports occupancy count, almost-full and almost-empty thresholds, and overflow/underflow pulses. It supports a full-with-simultaneous-read pass, and a build-time choice of standard (registered) or first-word-fall-through (FWFT) read mode. It sits between single-clock producer and consumer blocks as the default buffering primitive.

## Interface
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 32, number of entries; power of two, >=4
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through
- AF_THRESH, DEPTH-4, almost_full asserts when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
- A = $clog2(DEPTH), derived localparam

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- w_en  in  1  write request
- data_in  in  WIDTH  write data
- r_en  in  1  read request (in FWFT mode: pop/acknowledge of the current head)
- data_out  out  WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- count  out  A+1  occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
- Storage: DEPTH x WIDTH array, not reset. Pointers w_ptr and r_ptr are A+1 bits; the low A bits address the array. The MSB is a wrap bit.
- count = w_ptr - r_ptr, modulo 2^(A+1). empty = (w_ptr == r_ptr). full = low A bits equal and MSBs differ. All flags and count are combinational from registered pointers only.
- Read accept: rd_ok = r_en && !empty.
- Write accept: wr_ok = w_en && (!full || rd_ok). A write into a full FIFO is accepted when a read is accepted in the same cycle.
- On wr_ok: array[w_ptr[A-1:0]] <= data_in; w_ptr increments.
- On rd_ok: r_ptr increments.
- Pointers wrap naturally at 2^(A+1). No special case is needed.
- overflow <= w_en && !wr_ok. underflow <= r_en && !empty==0, i.e. r_en && empty. Both are registered, high for exactly one cycle per rejected request.
- Empty + w_en + r_en in the same cycle: the write is accepted and the read is rejected (underflow pulses). count becomes 1.
- Full + w_en + r_en in the same cycle: both are accepted and count stays DEPTH. The read returns the oldest word, never the word being written.
- FWFT=0: on rd_ok, data_out <= array[r_ptr[A-1:0]]. Otherwise data_out holds its value.
- FWFT=1: data_out = array[r_ptr[A-1:0]] when !empty, else all-zero. The head word is visible without r_en, and r_en removes it.

## Timing
- Reset values while rst is high and the cycle after: w_ptr=r_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (unless AF_THRESH==0, which is illegal), overflow=underflow=0, data_out=0.
- rst has priority over w_en/r_en in the same cycle. Reset mid-operation discards all contents. Array data is not cleared, but it is unreachable.
- Write latency: a word written at edge N updates count/empty/flags after edge N.
  - FWFT=1: that word appears on data_out after edge N, i.e. 1 cycle write-to-visible.
  - FWFT=0: the earliest read is r_en sampled at edge N+1, with data_out valid after edge N+1.
- Standard-mode read latency: data_out is valid the cycle after rd_ok.
- FWFT pop: the next head, or 0 if the FIFO is now empty, is visible after the rd_ok edge.
- Flag pulses (overflow/underflow) are asserted in the cycle after the offending request edge.

## Test plan
- Reset, then 32 writes of 0x00..0x1F (DEPTH=32): count steps 1..32; almost_full rises at count=28; full=1 at 32. A 33rd write (0xAA) gives overflow=1 for one cycle and count stays 32.
- From the full state, 32 reads (FWFT=0): data_out sequence 0x00..0x1F, each valid the cycle after r_en. empty=1 after the last read. A 33rd read gives underflow=1 and data_out holds 0x1F.
- Full FIFO with w_en=r_en=1 and data_in=0x55 for one cycle: no overflow, count stays 32, data_out=0x00. Draining then yields 0x01..0x1F, then 0x55.
- Empty FIFO with w_en=r_en=1 and data_in=0x3C: underflow pulses, count=1, empty=0. FWFT=1 build: data_out=0x3C the next cycle without r_en.
- Wrap-around: write 20 and read 20, then write 32 (0x80..0x9F). full=1 and count=32, and the reads return 0x80..0x9F in order.
- Reset mid-operation with count=10: the cycle after rst, count=0, empty=1, data_out=0, no flag pulses. A subsequent write/read of 0x77 returns 0x77.

Source files
------------

// File: rtl/sync_fifo_ext.sv
// ---------------------------------------------------------------------------
// sync_fifo_ext
//   Single-clock parametrised FIFO. Uses all DEPTH entries by carrying an
//   extra wrap bit on each pointer. Reports occupancy, almost-full and
//   almost-empty thresholds, and one-cycle overflow/underflow pulses.
//   A write into a full FIFO is accepted when a read is accepted in the same
//   cycle. Read mode is chosen at build time: registered read (FWFT=0) or
//   first-word-fall-through (FWFT=1).
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous active-high reset (priority over w_en/r_en)
//   w_en          write request
//   data_in       write data (WIDTH)
//   r_en          read request / FWFT pop of the current head
//   data_out      read data (WIDTH)
//   full          count == DEPTH
//   empty         count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         occupancy 0..DEPTH ($clog2(DEPTH)+1 bits)
//   overflow      one-cycle pulse after a rejected write
//   underflow     one-cycle pulse after a rejected read
// ---------------------------------------------------------------------------
module sync_fifo_ext #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 32,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_en,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     r_en,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int A = $clog2(DEPTH);

    localparam logic [A:0] PTR_ZERO_C = {(A + 1){1'b0}};
    localparam logic [A:0] PTR_ONE_C  = {{A{1'b0}}, 1'b1};
    localparam logic [A:0] AF_THR_C   = (A + 1)'(AF_THRESH);
    localparam logic [A:0] AE_THR_C   = (A + 1)'(AE_THRESH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [A:0]       w_ptr_r;
    logic [A:0]       r_ptr_r;
    logic [A:0]       count_s;
    logic             full_s;
    logic             empty_s;
    logic             rd_ok_s;
    logic             wr_ok_s;
    logic             overflow_r;
    logic             underflow_r;

    // Occupancy, flags and accept decisions, derived only from registered pointers.
    always_comb begin
        count_s  = w_ptr_r - r_ptr_r;
        empty_s  = (w_ptr_r == r_ptr_r);
        // Same slot but opposite wrap bit means the writer is a full lap ahead.
        full_s   = (w_ptr_r[A-1:0] == r_ptr_r[A-1:0]) && (w_ptr_r[A] != r_ptr_r[A]);
        rd_ok_s  = r_en && !empty_s;
        // A full FIFO still accepts a write when a slot is freed this cycle.
        wr_ok_s  = w_en && (!full_s || rd_ok_s);
    end

    assign count        = count_s;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_s >= AF_THR_C);
    assign almost_empty = (count_s <= AE_THR_C);
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

    // Storage array; intentionally not reset, stale data is unreachable after reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[w_ptr_r[A-1:0]] <= data_in;
        end
    end

    // Pointer advance and rejected-request pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr_r     <= PTR_ZERO_C;
            r_ptr_r     <= PTR_ZERO_C;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                w_ptr_r <= w_ptr_r + PTR_ONE_C;
            end
            if (rd_ok_s) begin
                r_ptr_r <= r_ptr_r + PTR_ONE_C;
            end
            overflow_r  <= w_en && !wr_ok_s;
            underflow_r <= r_en && empty_s;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; zero when nothing is stored.
            always_comb begin
                if (!empty_s) begin
                    data_out = mem_r[r_ptr_r[A-1:0]];
                end else begin
                    data_out = {WIDTH{1'b0}};
                end
            end
        end else begin : g_std
            logic [WIDTH-1:0] data_out_r;

            // Registered read; the array read sees the pre-edge contents, so a
            // same-cycle write into the head slot of a full FIFO is never returned.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_out_r <= {WIDTH{1'b0}};
                end else if (rd_ok_s) begin
                    data_out_r <= mem_r[r_ptr_r[A-1:0]];
                end
            end

            assign data_out = data_out_r;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ext.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_ext
//   Drives one standard-read and one FWFT instance with identical stimulus and
//   compares both against a queue-based model every cycle, plus directed
//   literal checks from the plan and a randomized phase.
// ---------------------------------------------------------------------------
module tb_sync_fifo_ext;

    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int AF    = DEPTH - 4;
    localparam int AE    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] std_dout, fw_dout;
    logic       std_full, std_empty, std_af, std_ae, std_ovf, std_udf;
    logic       fw_full, fw_empty, fw_af, fw_ae, fw_ovf, fw_udf;
    logic [5:0] std_count, fw_count;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit check_en  = 1'b0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_dout_std = 8'h00;
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;

    sync_fifo_ext #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(std_dout), .full(std_full), .empty(std_empty),
        .almost_full(std_af), .almost_empty(std_ae), .count(std_count),
        .overflow(std_ovf), .underflow(std_udf)
    );

    sync_fifo_ext #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) dut_f (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(fw_dout), .full(fw_full), .empty(fw_empty),
        .almost_full(fw_af), .almost_empty(fw_ae), .count(fw_count),
        .overflow(fw_ovf), .underflow(fw_udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behaviour from the rules: read frees the oldest word first, then a write
    // is accepted if there is room (including the room just freed).
    task automatic model_update(input bit r_st, input bit w, input bit r, input logic [7:0] d);
        bit rd_ok;
        bit wr_ok;
        if (r_st) begin
            q.delete();
            m_dout_std = 8'h00;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            rd_ok = r && (q.size() != 0);
            wr_ok = w && ((q.size() < DEPTH) || rd_ok);
            m_ovf = w && !wr_ok;
            m_udf = r && (q.size() == 0);
            if (rd_ok) m_dout_std = q.pop_front();
            if (wr_ok) q.push_back(d);
        end
    endtask

    // One clock cycle: drive on the falling edge, update the model at the
    // rising edge, return just after it so callers can sample outputs.
    task automatic step(input bit r_st, input bit w, input bit r, input logic [7:0] d);
        @(negedge clk);
        rst     = r_st;
        w_en    = w;
        r_en    = r;
        data_in = d;
        @(posedge clk);
        model_update(r_st, w, r, d);
        #1;
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int n;
        logic [7:0] head;
        if (check_en) begin
            n    = q.size();
            head = (n != 0) ? q[0] : 8'h00;
            chk("std_count", {26'd0, std_count}, n);
            chk("std_full",  {31'd0, std_full},  n == DEPTH);
            chk("std_empty", {31'd0, std_empty}, n == 0);
            chk("std_af",    {31'd0, std_af},    n >= AF);
            chk("std_ae",    {31'd0, std_ae},    n <= AE);
            chk("std_ovf",   {31'd0, std_ovf},   m_ovf);
            chk("std_udf",   {31'd0, std_udf},   m_udf);
            chk("std_dout",  {24'd0, std_dout},  {24'd0, m_dout_std});
            chk("fw_count",  {26'd0, fw_count},  n);
            chk("fw_full",   {31'd0, fw_full},   n == DEPTH);
            chk("fw_empty",  {31'd0, fw_empty},  n == 0);
            chk("fw_ovf",    {31'd0, fw_ovf},    m_ovf);
            chk("fw_udf",    {31'd0, fw_udf},    m_udf);
            chk("fw_dout",   {24'd0, fw_dout},   {24'd0, head});
        end
    end

    initial begin
        int wp;
        int rp;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check_en = 1'b1;
        step(1'b1, 1'b1, 1'b1, 8'hEE);
        chk("rst_count", {26'd0, std_count}, 32'd0);
        chk("rst_empty", {31'd0, std_empty}, 32'd1);
        chk("rst_dout",  {24'd0, std_dout},  32'd0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst_ae", {31'd0, std_ae}, 32'd1);
        chk("rst_af", {31'd0, std_af}, 32'd0);

        // Fill 0x00..0x1F
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, 1'b0, i[7:0]);
            chk("fill_count", {26'd0, std_count}, i + 1);
            if (i == 26) chk("fill_af_27", {31'd0, std_af}, 32'd0);
            if (i == 27) chk("fill_af_28", {31'd0, std_af}, 32'd1);
        end
        chk("fill_full", {31'd0, std_full}, 32'd1);
        chk("fw_head0",  {24'd0, fw_dout},  32'h00);

        step(1'b0, 1'b1, 1'b0, 8'hAA);
        chk("ovf_pulse", {31'd0, std_ovf},   32'd1);
        chk("ovf_count", {26'd0, std_count}, 32'd32);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("ovf_clear", {31'd0, std_ovf},   32'd0);

        // Drain 0x00..0x1F
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk("drain_dout", {24'd0, std_dout}, i);
        end
        chk("drain_empty", {31'd0, std_empty}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("udf_pulse", {31'd0, std_udf},  32'd1);
        chk("udf_hold",  {24'd0, std_dout}, 32'h1F);

        // Full with simultaneous read and write
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b0, i[7:0]);
        step(1'b0, 1'b1, 1'b1, 8'h55);
        chk("fwr_ovf",   {31'd0, std_ovf},   32'd0);
        chk("fwr_count", {26'd0, std_count}, 32'd32);
        chk("fwr_dout",  {24'd0, std_dout},  32'h00);
        chk("fwr_fhead", {24'd0, fw_dout},   32'h01);
        for (int i = 1; i <= 32; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk("fwr_drain", {24'd0, std_dout}, (i == 32) ? 32'h55 : i);
        end

        // Empty with simultaneous read and write
        step(1'b0, 1'b1, 1'b1, 8'h3C);
        chk("ewr_udf",   {31'd0, std_udf},   32'd1);
        chk("ewr_count", {26'd0, std_count}, 32'd1);
        chk("ewr_empty", {31'd0, std_empty}, 32'd0);
        chk("ewr_fwft",  {24'd0, fw_dout},   32'h3C);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("ewr_read",  {24'd0, std_dout},  32'h3C);

        // Wrap-around
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, i[7:0]);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b0, 8'h80 + i[7:0]);
        chk("wrap_full",  {31'd0, std_full},  32'd1);
        chk("wrap_count", {26'd0, std_count}, 32'd32);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk("wrap_dout", {24'd0, std_dout}, 32'h80 + i);
        end

        // Reset mid-operation
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 8'h10 + i[7:0]);
        chk("mid_count10", {26'd0, std_count}, 32'd10);
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("mid_count", {26'd0, std_count}, 32'd0);
        chk("mid_empty", {31'd0, std_empty}, 32'd1);
        chk("mid_dout",  {24'd0, std_dout},  32'd0);
        chk("mid_flags", {30'd0, std_ovf, std_udf}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 8'h77);
        chk("mid_fw77", {24'd0, fw_dout}, 32'h77);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("mid_rd77", {24'd0, std_dout}, 32'h77);

        // Randomized phase with biased segments to reach full and empty often
        for (int seg = 0; seg < 8; seg++) begin
            wp = (seg % 2 == 0) ? 75 : 25;
            rp = 100 - wp;
            for (int c = 0; c < 400; c++) begin
                step($urandom_range(0, 299) == 0,
                     $urandom_range(0, 99) < wp,
                     $urandom_range(0, 99) < rp,
                     8'($urandom));
            end
        end

        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
